// File: rtl/mvm_pkg.sv
// Shared widths, word counts and FSM state encoding for the MVM frame sequencer.
package mvm_pkg;
    localparam int R             = 8;
    localparam int C             = 8;
    localparam int W_X           = 4;
    localparam int W_K           = 4;
    localparam int W_Y_OUT       = 16;
    localparam int BITS_PER_WORD = 8;

    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int W_BUS_KX   = R * C * W_K + C * W_X;
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = R * W_Y_OUT / BITS_PER_WORD;
    localparam int W_RXC      = $clog2(N_WORDS_KX);
    localparam int W_TXC      = $clog2(N_WORDS_Y);

    typedef enum logic [1:0] {S_RX, S_KX, S_Y, S_TX} state_t;

    function automatic logic [W_Y_OUT-1:0] sext_y(input logic [W_Y-1:0] v);
        return {{(W_Y_OUT - W_Y){v[W_Y-1]}}, v};
    endfunction
endpackage

// File: rtl/word_packer.sv
// Word-addressed write port into a wide register; slot 0 lands in the LSBs.
module word_packer #(
    parameter int N_WORDS = 36,
    parameter int W       = 8,
    parameter int IW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [W-1:0]         wr_data,
    output logic [N_WORDS*W-1:0] data
);
    logic [W-1:0] slot [N_WORDS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_WORDS; i++) slot[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_WORDS; i++)
                if (wr_idx == IW'(i)) slot[i] <= wr_data;
        end
    end

    for (genvar i = 0; i < N_WORDS; i++) begin : g_slot
        assign data[i*W +: W] = slot[i];
    end
endmodule

// File: rtl/mvm_frame_sequencer.sv
// One MVM per UART frame: gather K/X words, hand off to the engine, stream the
// sign-extended result back out byte by byte.
module mvm_frame_sequencer
    import mvm_pkg::*;
#(
    parameter int RX_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_rx_valid,
    input  logic [BITS_PER_WORD-1:0] s_rx_data,
    output logic                     m_kx_valid,
    input  logic                     m_kx_ready,
    output logic [W_BUS_KX-1:0]      m_kx_data,
    input  logic                     s_y_valid,
    output logic                     s_y_ready,
    input  logic [R*W_Y-1:0]         s_y_data,
    output logic                     m_tx_valid,
    input  logic                     m_tx_ready,
    output logic [BITS_PER_WORD-1:0] m_tx_data,
    output logic                     busy,
    output logic                     err_overrun
);
    localparam int W_IDLE = $clog2(RX_TIMEOUT + 1);

    state_t                 state, state_nxt;
    logic [W_RXC-1:0]       rx_cnt, wr_idx;
    logic [W_IDLE-1:0]      idle_cnt;
    logic [W_TXC-1:0]       tx_cnt;
    logic [R*W_Y_OUT-1:0]   y_res;
    logic                   tx_last, rx_take, rx_last, timeout;

    assign m_kx_valid = (state == S_KX);
    assign s_y_ready  = (state == S_Y);
    assign m_tx_valid = (state == S_TX);
    assign busy       = (state != S_RX);

    assign tx_last = m_tx_valid && m_tx_ready && (tx_cnt == W_TXC'(N_WORDS_Y - 1));
    // The cycle that finishes TX already belongs to the next frame's RX window.
    assign rx_take = s_rx_valid && ((state == S_RX) || tx_last);
    assign timeout = (state == S_RX) && (rx_cnt != '0) && (idle_cnt == W_IDLE'(RX_TIMEOUT - 1));
    assign wr_idx  = timeout ? '0 : rx_cnt;
    assign rx_last = rx_take && (wr_idx == W_RXC'(N_WORDS_KX - 1));

    assign m_tx_data = m_tx_valid ? y_res[int'(tx_cnt)*BITS_PER_WORD +: BITS_PER_WORD] : '0;

    word_packer #(.N_WORDS(N_WORDS_KX), .W(BITS_PER_WORD), .IW(W_RXC)) u_rx_pack (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (rx_take),
        .wr_idx  (wr_idx),
        .wr_data (s_rx_data),
        .data    (m_kx_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_RX;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RX: if (rx_last)                  state_nxt = S_KX;
            S_KX: if (m_kx_ready)               state_nxt = S_Y;
            S_Y:  if (s_y_valid)                state_nxt = S_TX;
            S_TX: if (tx_last)                  state_nxt = S_RX;
            default:                            state_nxt = S_RX;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt      <= '0;
            idle_cnt    <= '0;
            tx_cnt      <= '0;
            y_res       <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (rx_take)      rx_cnt <= rx_last ? '0 : wr_idx + 1'b1;
            else if (timeout) rx_cnt <= '0;

            if (state != S_RX || rx_cnt == '0 || rx_take || timeout) idle_cnt <= '0;
            else                                                      idle_cnt <= idle_cnt + 1'b1;

            if (m_tx_valid && m_tx_ready) tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;

            if (s_y_valid && s_y_ready)
                for (int r = 0; r < R; r++)
                    y_res[r*W_Y_OUT +: W_Y_OUT] <= sext_y(s_y_data[r*W_Y +: W_Y]);

            if (tx_last)                            err_overrun <= 1'b0;
            else if (s_rx_valid && state != S_RX)   err_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mvm_frame_sequencer.sv
// Directed bench for mvm_frame_sequencer with a behavioural MVM model on the engine side.
module tb_mvm_frame_sequencer;
    import mvm_pkg::*;

    localparam int TO = 4096;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     s_rx_valid = 1'b0;
    logic [BITS_PER_WORD-1:0] s_rx_data = '0;
    logic                     m_kx_valid;
    logic                     m_kx_ready = 1'b0;
    logic [W_BUS_KX-1:0]      m_kx_data;
    logic                     s_y_valid = 1'b0;
    logic                     s_y_ready;
    logic [R*W_Y-1:0]         s_y_data = '0;
    logic                     m_tx_valid;
    logic                     m_tx_ready = 1'b0;
    logic [BITS_PER_WORD-1:0] m_tx_data;
    logic                     busy;
    logic                     err_overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] frame [N_WORDS_KX];

    mvm_frame_sequencer #(.RX_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .s_rx_valid(s_rx_valid), .s_rx_data(s_rx_data),
        .m_kx_valid(m_kx_valid), .m_kx_ready(m_kx_ready), .m_kx_data(m_kx_data),
        .s_y_valid(s_y_valid), .s_y_ready(s_y_ready), .s_y_data(s_y_data),
        .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready), .m_tx_data(m_tx_data),
        .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_BUS_KX-1:0] frame_bus();
        logic [W_BUS_KX-1:0] b;
        for (int i = 0; i < N_WORDS_KX; i++) b[i*8 +: 8] = frame[i];
        return b;
    endfunction

    function automatic int y_model(input int r);
        logic [W_BUS_KX-1:0] b;
        logic signed [W_X-1:0] x;
        logic signed [W_K-1:0] k;
        int acc;
        acc = 0;
        b = frame_bus();
        for (int c = 0; c < C; c++) begin
            x = b[c*W_X +: W_X];
            k = b[C*W_X + (r*C + c)*W_K +: W_K];
            acc += int'(k) * int'(x);
        end
        return acc;
    endfunction

    function automatic logic [R*W_Y-1:0] y_bus();
        logic [R*W_Y-1:0] b;
        logic [W_Y-1:0] e;
        for (int r = 0; r < R; r++) begin
            e = W_Y'(y_model(r));
            b[r*W_Y +: W_Y] = e;
        end
        return b;
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        logic [15:0] v;
        v = 16'(y_model(k / 2));
        return (k % 2) ? v[15:8] : v[7:0];
    endfunction

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            s_rx_valid = 1'b1;
            s_rx_data  = frame[i];
            tick();
        end
        s_rx_valid = 1'b0;
        s_rx_data  = '0;
    endtask

    task automatic send_frame(input string tag);
        send_range(0, N_WORDS_KX - 2);
        n_cmp++;
        if (m_kx_valid !== 1'b0) begin
            n_err++; $display("FAIL %s kx_early: m_kx_valid=%b want 0", tag, m_kx_valid);
        end
        send_range(N_WORDS_KX - 1, N_WORDS_KX - 1);
        n_cmp++;
        if (m_kx_valid !== 1'b1) begin
            n_err++; $display("FAIL %s kx_latency: m_kx_valid=%b want 1", tag, m_kx_valid);
        end
    endtask

    task automatic run_kx(input string tag, input int hold);
        int n, bad;
        n = 0; bad = 0;
        while (!m_kx_valid && n < 20) begin tick(); n++; end
        n_cmp++;
        if (m_kx_data !== frame_bus()) begin
            n_err++; $display("FAIL %s kx_data: got %h want %h", tag, m_kx_data, frame_bus());
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            if (m_kx_valid !== 1'b1 || m_kx_data !== frame_bus()) bad++;
        end
        if (hold > 0) begin
            n_cmp++;
            if (bad != 0) begin
                n_err++; $display("FAIL %s kx_hold: %0d unstable cycles, want 0", tag, bad);
            end
        end
        m_kx_ready = 1'b1;
        tick();
        m_kx_ready = 1'b0;
        n_cmp++;
        if (s_y_ready !== 1'b1 || m_kx_valid !== 1'b0) begin
            n_err++; $display("FAIL %s kx_hs: s_y_ready=%b m_kx_valid=%b want 1/0", tag, s_y_ready, m_kx_valid);
        end
    endtask

    task automatic run_y(input string tag);
        s_y_data  = y_bus();
        s_y_valid = 1'b1;
        tick();
        s_y_valid = 1'b0;
        n_cmp++;
        if (m_tx_valid !== 1'b1 || s_y_ready !== 1'b0) begin
            n_err++; $display("FAIL %s y_capture: m_tx_valid=%b s_y_ready=%b want 1/0", tag, m_tx_valid, s_y_ready);
        end
    endtask

    task automatic run_tx(input string tag, input bit rnd, input int stop_after, input bit use_const,
                          input logic [7:0] c_lo, input logic [7:0] c_hi, input bit send_next, input logic [7:0] nb);
        int got, cyc;
        logic pv, v;
        logic [7:0] pd, d, e;
        got = 0; cyc = 0; pv = 1'b0; pd = '0;
        while (got < stop_after && cyc < 400) begin
            m_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            v = m_tx_valid;
            d = m_tx_data;
            if (pv) begin
                n_cmp++;
                if (v !== 1'b1 || d !== pd) begin
                    n_err++; $display("FAIL %s tx_hold: valid=%b data=%h want 1/%h", tag, v, d, pd);
                end
            end
            pv = v && !m_tx_ready;
            pd = d;
            if (v && m_tx_ready) begin
                e = use_const ? ((got % 2) ? c_hi : c_lo) : exp_byte(got);
                n_cmp++;
                if (d !== e) begin
                    n_err++; $display("FAIL %s tx_word%0d: got %h want %h", tag, got, d, e);
                end
                if (send_next && got == N_WORDS_Y - 1) begin
                    s_rx_valid = 1'b1;
                    s_rx_data  = nb;
                end
                got++;
            end
            tick();
            s_rx_valid = 1'b0;
            cyc++;
        end
        m_tx_ready = 1'b0;
        if (got < stop_after) begin
            n_cmp++; n_err++;
            $display("FAIL %s tx_timeout: got %0d words want %0d", tag, got, stop_after);
        end
        if (stop_after == N_WORDS_Y) begin
            n_cmp++;
            if (m_tx_valid !== 1'b0 || busy !== 1'b0 || err_overrun !== 1'b0) begin
                n_err++; $display("FAIL %s tx_end: valid=%b busy=%b err=%b want 0/0/0", tag, m_tx_valid, busy, err_overrun);
            end
        end
    endtask

    task automatic fill(input logic [7:0] k_byte, input logic [7:0] x_byte);
        for (int i = 0; i < N_WORDS_KX; i++) frame[i] = (i < C*W_X/8) ? x_byte : k_byte;
    endtask

    task automatic fill_pattern(input int seed);
        for (int i = 0; i < N_WORDS_KX; i++) frame[i] = 8'(i * 37 + seed * 11 + 5);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_cmp++;
        if (m_kx_valid !== 1'b0 || s_y_ready !== 1'b0 || m_tx_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: kx=%b y_rdy=%b tx=%b want 0/0/0", m_kx_valid, s_y_ready, m_tx_valid);
        end
        n_cmp++;
        if (m_tx_data !== 8'h00 || busy !== 1'b0 || err_overrun !== 1'b0 || m_kx_data !== '0) begin
            n_err++; $display("FAIL reset_data: tx_data=%h busy=%b err=%b kx_nz=%b want 0", m_tx_data, busy, err_overrun, |m_kx_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_ones();
        fill(8'h11, 8'h11);
        send_frame("ones");
        run_kx("ones", 0);
        run_y("ones");
        run_tx("ones", 1'b0, N_WORDS_Y, 1'b1, 8'h08, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_negative();
        fill(8'h88, 8'h88);
        send_frame("neg8");
        run_kx("neg8", 0);
        run_y("neg8");
        run_tx("neg8", 1'b0, N_WORDS_Y, 1'b1, 8'h00, 8'h02, 1'b0, 8'h00);
        fill(8'h88, 8'h77);
        send_frame("negx7");
        run_kx("negx7", 0);
        run_y("negx7");
        run_tx("negx7", 1'b0, N_WORDS_Y, 1'b1, 8'h40, 8'hFE, 1'b0, 8'h00);
    endtask

    task automatic test_timeout();
        fill(8'h33, 8'h33);
        send_range(0, 19);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL to_partial_busy: busy=%b want 0", busy);
        end
        repeat (TO + 2) tick();
        fill_pattern(3);
        send_range(0, 15);
        n_cmp++;
        if (m_kx_valid !== 1'b0) begin
            n_err++; $display("FAIL to_drop: m_kx_valid=%b want 0", m_kx_valid);
        end
        send_range(16, N_WORDS_KX - 1);
        n_cmp++;
        if (m_kx_valid !== 1'b1) begin
            n_err++; $display("FAIL to_full: m_kx_valid=%b want 1", m_kx_valid);
        end
        run_kx("timeout", 0);
        run_y("timeout");
        run_tx("timeout", 1'b0, N_WORDS_Y, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_backpressure();
        fill_pattern(7);
        send_frame("bp");
        run_kx("bp", 50);
        run_y("bp");
        run_tx("bp", 1'b1, N_WORDS_Y, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_overrun();
        fill_pattern(9);
        send_frame("ovr");
        run_kx("ovr", 0);
        s_rx_valid = 1'b1;
        s_rx_data  = 8'hA5;
        tick();
        s_rx_valid = 1'b0;
        n_cmp++;
        if (err_overrun !== 1'b1 || s_y_ready !== 1'b1) begin
            n_err++; $display("FAIL ovr_flag: err=%b s_y_ready=%b want 1/1", err_overrun, s_y_ready);
        end
        run_y("ovr");
        n_cmp++;
        if (err_overrun !== 1'b1) begin
            n_err++; $display("FAIL ovr_sticky: err=%b want 1", err_overrun);
        end
        run_tx("ovr", 1'b0, N_WORDS_Y, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] nb;
        fill(8'h11, 8'h11);
        send_frame("b2b_a");
        run_kx("b2b_a", 0);
        run_y("b2b_a");
        fill_pattern(13);
        nb = frame[0];
        run_tx("b2b_a", 1'b0, N_WORDS_Y, 1'b1, 8'h08, 8'h00, 1'b1, nb);
        send_range(1, N_WORDS_KX - 1);
        n_cmp++;
        if (m_kx_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_word0: m_kx_valid=%b want 1", m_kx_valid);
        end
        run_kx("b2b_b", 0);
        run_y("b2b_b");
        run_tx("b2b_b", 1'b0, N_WORDS_Y, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_tx();
        fill_pattern(21);
        send_frame("rst_a");
        run_kx("rst_a", 0);
        run_y("rst_a");
        run_tx("rst_a", 1'b0, 5, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (m_tx_valid !== 1'b0 || busy !== 1'b0 || m_tx_data !== 8'h00 || m_kx_data !== '0) begin
            n_err++; $display("FAIL rst_abort: tx_valid=%b busy=%b tx_data=%h kx_nz=%b want 0", m_tx_valid, busy, m_tx_data, |m_kx_data);
        end
        repeat (2) tick();
        rstn = 1'b1;
        m_tx_ready = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (m_tx_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_release: m_tx_valid=%b want 0", m_tx_valid);
        end
        m_tx_ready = 1'b0;
        fill_pattern(29);
        send_frame("rst_b");
        run_kx("rst_b", 0);
        run_y("rst_b");
        run_tx("rst_b", 1'b1, N_WORDS_Y, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_negative();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
